apb_bridge_ctrl: RTL and testbench
==================================

// Module: apb_bridge_ctrl
// PURPOSE
//  Parametrised AHB-slave to APB-master bridge controller: one AHB slave port, NSLV APB slaves.
//  Qualifies AHB transfers, decodes the target APB slave and runs the SETUP/ACCESS sequence.
//  Honours PREADY wait states and maps PSLVERR to a two-cycle AHB ERROR response.
//  Sits between the AHB interconnect and the APB peripheral cluster.
// PARAMETERS
//  ADDR_W     32   AHB/APB address width
//  DATA_W     32   AHB/APB data width
//  NSLV       4    number of APB slaves (1..16)
//  SEL_LSB    12   LSB of slave-index field; index = haddr[SEL_LSB +: clog2(NSLV)] (0 if NSLV==1)
//  TIMEOUT    255  ACCESS-cycle limit, used only with APB_TIMEOUT_EN (1..65535)
// PORTS
//  hclk       in   1            system clock, all logic rising-edge
//  hreset_n   in   1            asynchronous active-low reset
//  hsel       in   1            AHB slave select
//  hready     in   1            AHB bus ready (previous transfer complete)
//  htrans     in   2            AHB transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
//  hwrite     in   1            AHB write/read
//  haddr      in   ADDR_W       AHB address
//  hwdata     in   DATA_W       AHB write data (valid the cycle after the address phase)
//  hreadyout  out  1            AHB ready response
//  hresp      out  1            AHB response, 0=OKAY 1=ERROR
//  hrdata     out  DATA_W       AHB read data
//  psel       out  NSLV         one-hot APB select
//  penable    out  1            APB enable
//  paddr      out  ADDR_W       APB address
//  pwrite     out  1            APB direction
//  pwdata     out  DATA_W       APB write data
//  prdata     in   NSLV*DATA_W  read data, slave i on [i*DATA_W +: DATA_W]
//  pready     in   NSLV         per-slave ready
//  pslverr    in   NSLV         per-slave error
// BEHAVIOUR
//  Reset: state=IDLE; hreadyout=1; hresp=0; hrdata=0; psel=0; penable=0; paddr=0; pwrite=0; pwdata=0.
//  Valid transfer = hsel & hready & htrans[1]. Accepted only in IDLE, DONE or ERR2; otherwise ignored.
//  On accept, register haddr, hwrite and slave index. IDLE/BUSY/unselected in those states -> IDLE.
//  States (all outputs registered):
//   IDLE  : hreadyout=1, hresp=0, psel=0.
//   LATCH : hreadyout=0; capture hwdata into pwdata on writes; index>=NSLV -> ERR1, else SETUP.
//   SETUP : psel[idx]=1, penable=0; paddr/pwrite/pwdata stable -> ACCESS.
//   ACCESS: psel[idx]=1, penable=1; hold until pready[idx] (other slaves' pready/pslverr ignored).
//           pready&!pslverr -> DONE, hrdata<=prdata[idx] on reads; pready&pslverr -> ERR1.
//   DONE  : hreadyout=1, hresp=0, psel=0, penable=0; new valid -> LATCH, else IDLE.
//   ERR1  : hreadyout=0, hresp=1, psel=0 -> ERR2.
//   ERR2  : hreadyout=1, hresp=1; new valid -> LATCH (master may cancel via IDLE), else IDLE.
//  Latency, zero-wait slave: address phase T; LATCH T+1; SETUP T+2; ACCESS T+3; DONE T+4.
//  Each pready wait cycle adds one cycle. Back-to-back transfers: 4 cycles each.
//  paddr = full registered haddr (no truncation). hrdata holds last read value; writes leave it unchanged.
//  psel strictly one-hot or zero. penable never asserted without psel. psel/penable drop the cycle after the final ACCESS.
//  Reset mid-transfer: all outputs return to reset values immediately; no response completes the transfer.
// CONFIGURATION
//  APB_TIMEOUT_EN defined: counter clears on SETUP->ACCESS and increments each ACCESS cycle without pready[idx].
//   At TIMEOUT waiting cycles, drop psel/penable and go to ERR1 (AHB ERROR); late pready ignored.
//  APB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; TIMEOUT unused.
// TESTING
//  1 Reset: hreset_n=0 mid-ACCESS -> next sample psel=0, penable=0, hreadyout=1, hresp=0.
//  2 Write, haddr=0x0000_2004, hwdata=0xDEAD_BEEF, pready=1 -> psel=4'b0100 in SETUP, paddr=0x2004,
//    pwdata=0xDEADBEEF, penable next cycle, hreadyout=1 at T+4, hresp=0.
//  3 Read slave 1 with 3 wait cycles, prdata=0x1234_5678 -> hrdata=0x12345678 and hreadyout=1 at T+7.
//  4 pslverr=1 with pready on a write -> ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1), then IDLE.
//  5 NSLV=3, address index 3 -> no psel pulse; ERROR response 1 cycle after LATCH. Back-to-back NONSEQ accepted in DONE.
//  6 APB_TIMEOUT_EN, TIMEOUT=8, pready held 0 -> penable drops after 8 ACCESS wait cycles, then two-cycle ERROR.
//    Macro off: still waiting at cycle 100.

Source files
------------

// File: rtl/apb_bridge_ctrl.sv
// AHB-slave to APB-master bridge: qualifies AHB transfers, decodes one of NSLV slaves, runs SETUP/ACCESS.
// Latency: 4 cycles from address phase to hreadyout for a zero-wait slave, +1 per pready wait cycle.
// Backpressure: hreadyout low while a transfer is in flight; optional APB_TIMEOUT_EN bounds ACCESS waits.
module apb_bridge_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int NSLV    = 4,
   parameter int SEL_LSB = 12,
   parameter int TIMEOUT = 255
) (
   input  logic                   hclk,
   input  logic                   hreset_n,
   input  logic                   hsel,
   input  logic                   hready,
   input  logic [1:0]             htrans,
   input  logic                   hwrite,
   input  logic [ADDR_W-1:0]      haddr,
   input  logic [DATA_W-1:0]      hwdata,
   output logic                   hreadyout,
   output logic                   hresp,
   output logic [DATA_W-1:0]      hrdata,
   output logic [NSLV-1:0]        psel,
   output logic                   penable,
   output logic [ADDR_W-1:0]      paddr,
   output logic                   pwrite,
   output logic [DATA_W-1:0]      pwdata,
   input  logic [NSLV*DATA_W-1:0] prdata,
   input  logic [NSLV-1:0]        pready,
   input  logic [NSLV-1:0]        pslverr
);

   localparam int IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;
   localparam logic [IDX_W:0] NSLV_L = (IDX_W+1)'(NSLV);

   typedef enum logic [2:0] {
      S_IDLE, S_LATCH, S_SETUP, S_ACCESS, S_DONE, S_ERR1, S_ERR2
   } state_t;

   state_t state, state_nxt;

   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  haddr_idx;
   logic              xfer_vld;
   logic              accept;
   logic              slv_rdy;
   logic              slv_err;
   logic              tmo_hit;
   logic [NSLV-1:0]   sel_onehot;
   logic [DATA_W-1:0] slv_rdata;

   if (NSLV > 1) begin : g_idx
      assign haddr_idx = haddr[SEL_LSB +: IDX_W];
   end else begin : g_idx_single
      assign haddr_idx = '0;
   end

   assign xfer_vld = hsel & hready & htrans[1];
   assign accept   = xfer_vld & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR2));

   // Loop-based select keeps out-of-range indices (non power-of-two NSLV) from reading past the buses.
   always_comb begin
      slv_rdy    = 1'b0;
      slv_err    = 1'b0;
      slv_rdata  = '0;
      sel_onehot = '0;
      for (int i = 0; i < NSLV; i++) begin
         if (idx == IDX_W'(i)) begin
            slv_rdy       = pready[i];
            slv_err       = pslverr[i];
            slv_rdata     = prdata[i*DATA_W +: DATA_W];
            sel_onehot[i] = 1'b1;
         end
      end
   end

`ifdef APB_TIMEOUT_EN
   logic [15:0] tmo_cnt;

   assign tmo_hit = (tmo_cnt == 16'(TIMEOUT - 1));

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         tmo_cnt <= '0;
      end else if (state == S_SETUP) begin
         tmo_cnt <= '0;
      end else if ((state == S_ACCESS) && !slv_rdy) begin
         tmo_cnt <= tmo_cnt + 16'd1;
      end
   end
`else
   logic unused_timeout;

   assign tmo_hit        = 1'b0;
   assign unused_timeout = (TIMEOUT == 0);
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (accept) state_nxt = S_LATCH;
         S_LATCH:  state_nxt = ({1'b0, idx} >= NSLV_L) ? S_ERR1 : S_SETUP;
         S_SETUP:  state_nxt = S_ACCESS;
         S_ACCESS: begin
            if (slv_rdy)      state_nxt = slv_err ? S_ERR1 : S_DONE;
            else if (tmo_hit) state_nxt = S_ERR1;
         end
         S_DONE:   state_nxt = accept ? S_LATCH : S_IDLE;
         S_ERR1:   state_nxt = S_ERR2;
         S_ERR2:   state_nxt = accept ? S_LATCH : S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state     <= S_IDLE;
         idx       <= '0;
         hreadyout <= 1'b1;
         hresp     <= 1'b0;
         hrdata    <= '0;
         psel      <= '0;
         penable   <= 1'b0;
         paddr     <= '0;
         pwrite    <= 1'b0;
         pwdata    <= '0;
      end else begin
         state     <= state_nxt;
         hreadyout <= (state_nxt == S_IDLE) || (state_nxt == S_DONE) || (state_nxt == S_ERR2);
         hresp     <= (state_nxt == S_ERR1) || (state_nxt == S_ERR2);
         psel      <= ((state_nxt == S_SETUP) || (state_nxt == S_ACCESS)) ? sel_onehot : '0;
         penable   <= (state_nxt == S_ACCESS);
         if (accept) begin
            idx    <= haddr_idx;
            paddr  <= haddr;
            pwrite <= hwrite;
         end
         if ((state == S_LATCH) && pwrite) begin
            pwdata <= hwdata;
         end
         if ((state == S_ACCESS) && slv_rdy && !slv_err && !pwrite) begin
            hrdata <= slv_rdata;
         end
      end
   end

endmodule

// File: tb/tb_apb_bridge_ctrl.sv
// Randomised and directed transfers checked against a cycle-timeline model of the bridge.
module tb_apb_bridge_ctrl;
   localparam int NSLV = 3;
   localparam int DW   = 32;
   localparam int AW   = 32;
   localparam int TMO  = 8;

   logic             hclk = 1'b0;
   logic             hreset_n;
   logic             hsel, hready, hwrite;
   logic [1:0]       htrans;
   logic [AW-1:0]    haddr;
   logic [DW-1:0]    hwdata;
   logic             hreadyout, hresp, penable, pwrite;
   logic [DW-1:0]    hrdata, pwdata;
   logic [NSLV-1:0]  psel, pready, pslverr;
   logic [AW-1:0]    paddr;
   logic [NSLV*DW-1:0] prdata;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] last_read = '0;

   apb_bridge_ctrl #(
      .ADDR_W(AW), .DATA_W(DW), .NSLV(NSLV), .SEL_LSB(12), .TIMEOUT(TMO)
   ) dut (
      .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel), .hready(hready), .htrans(htrans),
      .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata), .hreadyout(hreadyout), .hresp(hresp),
      .hrdata(hrdata), .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
      .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 hclk = ~hclk;

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_cycle();
      hsel   = 1'($urandom);
      hready = 1'b1;
      htrans = 2'($urandom_range(0, 1));
      step();
      chk("idle_hreadyout", hreadyout, 1);
      chk("idle_hresp", hresp, 0);
      chk("idle_psel", psel, 0);
      chk("idle_penable", penable, 0);
   endtask

   // One AHB transfer; cycle n counts from the address phase (n=0).
   task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdat,
                      input logic [31:0] rdat, input int w, input logic err);
      int              idx;
      logic            inv, tmo, resp_err;
      int              last_acc, err1, fin;
      logic [NSLV-1:0] oh;
      idx = int'(addr[13:12]);
      inv = (idx >= NSLV);
      tmo = 1'b0;
`ifdef APB_TIMEOUT_EN
      tmo = !inv && (w >= TMO);
`endif
      err1 = 1 << 20;
      if (inv) begin
         last_acc = 0; err1 = 2; fin = 3; resp_err = 1'b1;
      end else if (tmo) begin
         last_acc = 2 + TMO; err1 = 3 + TMO; fin = 4 + TMO; resp_err = 1'b1;
      end else begin
         last_acc = 3 + w;
         resp_err = err;
         if (err) begin
            err1 = 4 + w; fin = 5 + w;
         end else begin
            fin = 4 + w;
         end
      end
      oh = '0;
      if (!inv) oh[idx] = 1'b1;

      chk("addr_phase_ready", hreadyout, 1);
      hsel = 1'b1; hready = 1'b1; htrans = 2'b10; hwrite = wr; haddr = addr;
      hwdata = $urandom;
      step();
      for (int n = 1; n <= fin; n++) begin
         hwdata = (n == 1) ? wdat : $urandom;
         if (n < fin) begin
            hsel = 1'($urandom); hready = 1'($urandom); htrans = 2'($urandom);
            hwrite = 1'($urandom); haddr = $urandom;
         end else begin
            hsel = 1'b0; hready = 1'b1; htrans = 2'b00;
         end
         pready  = NSLV'($urandom);
         pslverr = NSLV'($urandom);
         prdata  = {$urandom, $urandom, $urandom};
         if (!inv) begin
            pready[idx] = !tmo && (n == 3 + w);
            if (n == 3 + w) begin
               pslverr[idx]         = err;
               prdata[idx*DW +: DW] = rdat;
            end
         end
         chk("psel", psel, (n >= 2 && n <= last_acc) ? oh : '0);
         chk("penable", penable, (n >= 3 && n <= last_acc));
         chk("hreadyout", hreadyout, (n == fin));
         chk("hresp", hresp, (resp_err && n >= err1));
         chk("paddr", paddr, addr);
         chk("pwrite", pwrite, wr);
         if (wr && n >= 2) chk("pwdata", pwdata, wdat);
         if (n == fin) begin
            if (!wr && !resp_err) last_read = rdat;
            chk("hrdata", hrdata, last_read);
         end
         if (n < fin) step();
      end
   endtask

   initial begin
      hreset_n = 1'b0;
      hsel = 0; hready = 1; htrans = 0; hwrite = 0; haddr = 0; hwdata = 0;
      prdata = '0; pready = '0; pslverr = '0;
      step();
      step();
      chk("rst_hreadyout", hreadyout, 1);
      chk("rst_hresp", hresp, 0);
      chk("rst_psel", psel, 0);
      chk("rst_hrdata", hrdata, 0);
      chk("rst_paddr", paddr, 0);
      hreset_n = 1'b1;
      step();

      // Reset asserted while the slave is stalling in ACCESS
      hsel = 1; hready = 1; htrans = 2'b10; hwrite = 1; haddr = 32'h0000_1008;
      step();
      hsel = 0; htrans = 2'b00; hwdata = 32'hA5A5_0001;
      step();
      step();
      chk("mid_access_penable", penable, 1);
      #2 hreset_n = 1'b0;
      #1;
      chk("mid_rst_psel", psel, 0);
      chk("mid_rst_penable", penable, 0);
      chk("mid_rst_hreadyout", hreadyout, 1);
      chk("mid_rst_hresp", hresp, 0);
      chk("mid_rst_pwdata", pwdata, 0);
      step();
      hreset_n  = 1'b1;
      last_read = '0;
      step();

      txn(1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
      idle_cycle();
      txn(1'b0, 32'h0000_1000, 32'h0, 32'h1234_5678, 3, 1'b0);
      chk("read_hrdata", hrdata, 32'h1234_5678);
      txn(1'b1, 32'h0000_0010, 32'h0BAD_0BAD, 32'h0, 0, 1'b1);
      idle_cycle();
      txn(1'b0, 32'h0000_3000, 32'h0, 32'h0, 0, 1'b0);
      txn(1'b0, 32'h0000_2040, 32'h0, 32'hCAFE_F00D, 1, 1'b0);
      txn(1'b1, 32'h0000_0044, 32'h5555_AAAA, 32'h0, 0, 1'b0);

      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 3) == 0) idle_cycle();
         txn(1'($urandom), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 5)), ($urandom_range(0, 4) == 0));
      end

      txn(1'b0, 32'h0000_1100, 32'h0, 32'h7777_0000, 100, 1'b0);
      idle_cycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
